// File: rtl/shift_arb_pkg.sv
// Shared constants, types and helpers for the shift_arbiter block.
package shift_arb_pkg;

  localparam int NREQ    = 8;
  localparam int SHAMT_W = 5;
  localparam int ID_W    = 3;

  typedef logic [NREQ-1:0] grant_t;
  typedef logic [ID_W-1:0] id_t;

  // Converts a one-hot (or zero) grant vector into a slot index; zero maps to 0.
  function automatic id_t onehot_to_id(input grant_t g);
    id_t id;
    id = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (g[i]) id = id | id_t'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/shift_arbiter_if.sv
// Request, shifter and response bus of shift_arbiter; slave is the arbiter side.
interface shift_arbiter_if
  import shift_arb_pkg::*;
#(
  parameter int WIDTH = 32
);

  // Requester side
  grant_t                   req_valid;
  grant_t                   req_ready;
  logic [NREQ*WIDTH-1:0]    req_data;
  logic [NREQ*SHAMT_W-1:0]  req_shamt;
  grant_t                   req_arith;
  grant_t                   grant_sel;

  // Shared shifter
  logic [WIDTH-1:0]         sh_in;
  logic [SHAMT_W-1:0]       sh_shamt;
  logic                     sh_arith;
  logic [WIDTH-1:0]         sh_out;

  // Response channel
  logic                     resp_valid;
  logic                     resp_ready;
  logic [WIDTH-1:0]         resp_data;
  id_t                      resp_id;

  modport slave (
    input  req_valid, req_data, req_shamt, req_arith, sh_out, resp_ready,
    output req_ready, grant_sel, sh_in, sh_shamt, sh_arith,
           resp_valid, resp_data, resp_id
  );

  modport master (
    output req_valid, req_data, req_shamt, req_arith, sh_out, resp_ready,
    input  req_ready, grant_sel, sh_in, sh_shamt, sh_arith,
           resp_valid, resp_data, resp_id
  );

endinterface

// File: rtl/shift_arbiter_rr_picker.sv
// Combinational round-robin picker: first requesting slot at or after ptr, wrapping 7 -> 0.
module rr_picker
  import shift_arb_pkg::*;
(
  input  grant_t req,
  input  id_t    ptr,
  output grant_t grant,
  output id_t    gid
);

  id_t idx;

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    grant = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr + id_t'(i);
      if ((grant == '0) && req[idx]) grant[idx] = 1'b1;
    end
  end

  assign gid = onehot_to_id(grant);

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin sharing of one external right shifter among 8 requesters, two-stage pipeline.
// Optional per-slot saturating grant counters when SHIFT_ARB_STATS_EN is defined.
module shift_arbiter
  import shift_arb_pkg::*;
#(
  parameter int WIDTH = 32
)(
  input  logic            clk,
  input  logic            reset_n,
  shift_arbiter_if.slave  bus
`ifdef SHIFT_ARB_STATS_EN
  ,
  input  id_t             stat_idx,
  output logic [15:0]     stat_count
`endif
);

  // Stage A: operands currently presented to the shifter
  logic               a_valid;
  logic [WIDTH-1:0]   a_data;
  logic [SHAMT_W-1:0] a_shamt;
  logic               a_arith;
  id_t                a_id;

  // Stage B: registered result awaiting the consumer
  logic               resp_valid;
  logic [WIDTH-1:0]   resp_data;
  id_t                resp_id;

  id_t                rr_ptr;

  logic               b_load;
  logic               a_adv;
  logic               a_take;
  grant_t             pick;
  grant_t             grant;
  id_t                gid;
  logic               do_grant;

  logic [WIDTH-1:0]   slot_data  [NREQ];
  logic [SHAMT_W-1:0] slot_shamt [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    assign slot_data[i]  = bus.req_data[i*WIDTH +: WIDTH];
    assign slot_shamt[i] = bus.req_shamt[i*SHAMT_W +: SHAMT_W];
  end

  assign b_load = !resp_valid || bus.resp_ready;
  assign a_adv  = a_valid && b_load;
  assign a_take = !a_valid || a_adv;

  rr_picker u_picker (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (pick),
    .gid   (gid)
  );

  // Grants are suppressed while reset is held so no requester sees a phantom accept.
  assign grant    = (reset_n && a_take) ? pick : '0;
  assign do_grant = |grant;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_valid <= 1'b0;
      a_data  <= '0;
      a_shamt <= '0;
      a_arith <= 1'b0;
      a_id    <= '0;
      rr_ptr  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
      if (do_grant) begin
        a_valid <= 1'b1;
        a_data  <= slot_data[gid];
        a_shamt <= slot_shamt[gid];
        a_arith <= bus.req_arith[gid];
        a_id    <= gid;
        rr_ptr  <= gid + id_t'(1);
      end else if (a_adv) begin
        a_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
    end else if (a_adv) begin
      resp_valid <= 1'b1;
      resp_data  <= bus.sh_out;
      resp_id    <= a_id;
    end else if (resp_valid && bus.resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  assign bus.req_ready  = grant;
  assign bus.grant_sel  = grant;
  assign bus.sh_in      = a_data;
  assign bus.sh_shamt   = a_shamt;
  assign bus.sh_arith   = a_arith;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_data  = resp_data;
  assign bus.resp_id    = resp_id;

`ifdef SHIFT_ARB_STATS_EN
  logic [15:0] grant_cnt [NREQ];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: this small register array is reset because its cleared state is architecturally visible.
      for (int i = 0; i < NREQ; i++) grant_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (grant[i] && (grant_cnt[i] != 16'hFFFF)) grant_cnt[i] <= grant_cnt[i] + 16'd1;
      end
    end
  end

  assign stat_count = grant_cnt[stat_idx];
`endif

endmodule
